// File: rtl/fpmul_wb_stage.sv
`default_nettype none
// ============================================================================
// fpmul_wb_stage : tags FPMul issues, captures results into a FIFO, writes back
// Optional: FPMUL_WB_FLAGS_EN adds wb_flags {nan, inf, zero, denorm}
// Revision: 1.0
// ============================================================================
module fpmul_wb_stage #(
  parameter int MUL_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int RD_W        = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic [RD_W-1:0] issue_rd,
  output logic            issue_ready,
  input  logic [31:0]     mul_c,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data
`ifdef FPMUL_WB_FLAGS_EN
  ,
  output logic [3:0]      wb_flags
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = $clog2(FIFO_DEPTH + MUL_LATENCY + 1);

  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_W-1:0]        tag_rd_q [MUL_LATENCY];
  logic [RD_W-1:0]        tag_rd_d [MUL_LATENCY];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [RD_W-1:0]        mem_rd_q   [FIFO_DEPTH];
  logic [RD_W-1:0]        mem_rd_d   [FIFO_DEPTH];
  logic [31:0]            mem_data_q [FIFO_DEPTH];
  logic [31:0]            mem_data_d [FIFO_DEPTH];

  logic             issue_fire;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] inflight;

  // Credit is taken from registered state only, so a same-cycle pop is not counted.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      inflight = inflight + SUM_W'(tag_vld_q[i]);
    end
    issue_ready = (SUM_W'(count_q) + inflight) < SUM_W'(FIFO_DEPTH);
    wb_valid    = (count_q != '0);
    issue_fire  = issue_valid && issue_ready && !flush;
    push        = tag_vld_q[MUL_LATENCY-1];
    pop         = wb_valid && wb_ready;
    wb_rd       = wb_valid ? mem_rd_q[rd_ptr_q]   : '0;
    wb_data     = wb_valid ? mem_data_q[rd_ptr_q] : '0;
  end

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_rd_d     = tag_rd_q;
    tag_vld_d[0] = issue_fire;
    tag_rd_d[0]  = issue_rd;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_rd_d[i]  = tag_rd_q[i-1];
    end

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;

    if (flush) begin
      tag_vld_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (push) begin
        mem_rd_d[wr_ptr_q]   = tag_rd_q[MUL_LATENCY-1];
        mem_data_d[wr_ptr_q] = mul_c;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_rd_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_rd_q   <= tag_rd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
    end
  end

`ifdef FPMUL_WB_FLAGS_EN
  logic [3:0] mem_flags_q [FIFO_DEPTH];
  logic [3:0] mem_flags_d [FIFO_DEPTH];

  function automatic logic [3:0] classify(input logic [31:0] v);
    logic exp_ones;
    logic exp_zero;
    logic frac_nz;
    exp_ones = &v[30:23];
    exp_zero = ~|v[30:23];
    frac_nz  = |v[22:0];
    return {exp_ones && frac_nz, exp_ones && !frac_nz,
            exp_zero && !frac_nz, exp_zero && frac_nz};
  endfunction

  always_comb begin
    mem_flags_d = mem_flags_q;
    if (push && !flush) begin
      mem_flags_d[wr_ptr_q] = classify(mul_c);
    end
    wb_flags = wb_valid ? mem_flags_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_flags_q[i] <= '0;
      end
    end else begin
      mem_flags_q <= mem_flags_d;
    end
  end
`endif

  // The credit rule keeps count + inflight <= FIFO_DEPTH, so this never fires.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && count_q == CNT_W'(FIFO_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_fpmul_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_fpmul_wb_stage : scoreboard bench with a queue-level model of the stage
// Revision: 1.0
// ============================================================================
module tb_fpmul_wb_stage;

  localparam int ML    = 1;
  localparam int DEPTH = 4;
  localparam int RW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          issue_valid = 1'b0;
  logic [RW-1:0] issue_rd = '0;
  logic          issue_ready;
  logic [31:0]   mul_c = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [RW-1:0] wb_rd;
  logic [31:0]   wb_data;
`ifdef FPMUL_WB_FLAGS_EN
  logic [3:0]    wb_flags;
`endif

  fpmul_wb_stage #(.MUL_LATENCY(ML), .FIFO_DEPTH(DEPTH), .RD_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .mul_c(mul_c), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef FPMUL_WB_FLAGS_EN
    , .wb_flags(wb_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rd;
    logic [31:0]   data;
    int            due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          exp_ready = 1'b1;
  bit          pend_v [16];
  logic [31:0] pend_d [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // IEEE-754 class of a single-precision value: {nan, inf, zero, denorm}
  function automatic logic [3:0] fp_class(input logic [31:0] v);
    int unsigned e;
    int unsigned f;
    e = (v >> 23) & 32'hFF;
    f = v & 32'h7F_FFFF;
    if (e == 255) return (f != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)   return (f != 0) ? 4'b0001 : 4'b0010;
    return 4'b0000;
  endfunction

  // Monitor: compares the head against the oldest outstanding op.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_v;
      exp_v = (sb.size() > 0) && (sb[0].due <= cyc);
      check("issue_ready", 64'(issue_ready), 64'(exp_ready));
      check("wb_valid", 64'(wb_valid), 64'(exp_v));
      if (wb_valid && exp_v) begin
        check("wb_rd", 64'(wb_rd), 64'(sb[0].rd));
        check("wb_data", 64'(wb_data), 64'(sb[0].data));
`ifdef FPMUL_WB_FLAGS_EN
        check("wb_flags", 64'(wb_flags), 64'(fp_class(sb[0].data)));
`endif
      end else if (!wb_valid) begin
        check("wb_rd_idle", 64'(wb_rd), 64'd0);
        check("wb_data_idle", 64'(wb_data), 64'd0);
`ifdef FPMUL_WB_FLAGS_EN
        check("wb_flags_idle", 64'(wb_flags), 64'd0);
`endif
      end
      if (flush) sb.delete();
      else if (wb_valid && wb_ready && exp_v) void'(sb.pop_front());
    end
  end

  // Called just after a rising edge; drives one cycle and returns after the next edge.
  task automatic drive(input bit iv, input logic [RW-1:0] rd, input logic [31:0] res,
                       input bit rdy, input bit fl);
    int slot;
    exp_ready   = (sb.size() < DEPTH);
    issue_valid = iv;
    issue_rd    = rd;
    wb_ready    = rdy;
    flush       = fl;
    slot        = cyc % 16;
    mul_c       = pend_v[slot] ? pend_d[slot] : $urandom;
    pend_v[slot] = 1'b0;
    if (iv && exp_ready && !fl) begin
      sb.push_back('{rd: rd, data: res, due: cyc + ML + 1});
      pend_v[(cyc + ML) % 16] = 1'b1;
      pend_d[(cyc + ML) % 16] = res;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 32'h0, rdy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    check({tag, "_issue_ready"}, 64'(issue_ready), 64'd1);
`ifdef FPMUL_WB_FLAGS_EN
    check({tag, "_wb_flags"}, 64'(wb_flags), 64'd0);
`endif
  endtask

  function automatic logic [31:0] rand_value();
    case ($urandom_range(0, 7))
      0: return 32'h7F80_0000;
      1: return 32'h7FC0_0001;
      2: return 32'h0000_0000;
      3: return 32'h8000_0000;
      4: return 32'h0040_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op with immediate writeback
    drive(1'b1, 5'd3, 32'h44FA_0000, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Back-to-back ops
    drive(1'b1, 5'd1, 32'h44FA_0000, 1'b1, 1'b0);
    drive(1'b1, 5'd2, 32'hC477_8000, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Back-pressure: only DEPTH ops may be accepted
    for (int i = 0; i < 8; i++) drive(1'b1, RW'(10 + i), 32'h3F80_0000 + i, 1'b0, 1'b0);
    check("bp_held", 64'(sb.size()), 64'(DEPTH));
    idle(8, 1'b1);

    // Flush with ops in flight and buffered, plus an issue in the flush cycle
    for (int i = 0; i < 3; i++) drive(1'b1, RW'(20 + i), 32'h4000_0000 + i, 1'b0, 1'b0);
    drive(1'b1, 5'd31, 32'h1234_5678, 1'b0, 1'b1);
    idle(6, 1'b1);

    // Asynchronous reset with three entries buffered
    for (int i = 0; i < 3; i++) drive(1'b1, RW'(24 + i), 32'h4100_0000 + i, 1'b0, 1'b0);
    idle(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    exp_ready = 1'b1;
    issue_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(4, 1'b1);

    // Special-value classes
    drive(1'b1, 5'd5, 32'h7FC0_0000, 1'b1, 1'b0);
    drive(1'b1, 5'd6, 32'h8000_0000, 1'b1, 1'b0);
    drive(1'b1, 5'd7, 32'h0000_0001, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, RW'($urandom), rand_value(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end

    // Bounded drain
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1, 1'b1);
    check("drain_empty", 64'(sb.size()), 64'd0);
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
